// File: rtl/ysyx_23060208_clint_if.sv
// AXI4 read-address / read-data channels between the interconnect and the CLINT.
interface ysyx_23060208_clint_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      arready;
  logic                      arvalid;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [3:0]                arid;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      rready;
  logic                      rvalid;
  logic [1:0]                rresp;
  logic [DATA_WIDTH*2-1:0]   rdata;
  logic                      rlast;
  logic [3:0]                rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rresp, rdata, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rresp, rdata, rlast, rid
  );
endinterface

// File: rtl/ysyx_23060208_clint.sv
// Read-only CLINT: free-running 64-bit mtime with prescaler, served as an
// atomic 64-bit snapshot over AXI4 single-beat and INCR/FIXED bursts.
module ysyx_23060208_clint #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] CLINT_BASE = 'h0200_0000,
  parameter int                    DIVIDER    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  ysyx_23060208_clint_if.slave     bus
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                  state;
  logic [63:0]             mtime;
  logic [63:0]             snap;
  logic [31:0]             pcnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [7:0]              len;
  logic [7:0]              beat;
  logic [7:0]              beat_nxt;
  logic [2:0]              size;
  logic [1:0]              burst;

  logic                    arready_q;
  logic                    rvalid_q;
  logic                    rlast_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH*2-1:0] rdata_q;
  logic [3:0]              rid_q;

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign bus.rid     = rid_q;

  // Unsigned wrap of (a - base) makes a single compare cover both the
  // out-of-window case and the offset >= 8 case.
  function automatic logic beat_ok(input logic [ADDR_WIDTH-1:0] a,
                                   input logic [1:0] b, input logic [2:0] s);
    logic [ADDR_WIDTH-1:0] off;
    off = a - CLINT_BASE;
    return (off < ADDR_WIDTH'(8)) && (b != BURST_WRAP) && (s <= 3'd3);
  endfunction

  // Address and beat count of the following beat.
  always_comb begin
    addr_nxt = addr;
    if (burst == BURST_INCR) addr_nxt = addr + (ADDR_WIDTH'(1) << size);
    beat_nxt = beat + 8'd1;
  end

  // Prescaler and mtime, free-running independent of bus activity.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt  <= '0;
      mtime <= '0;
    end else if (pcnt == 32'(DIVIDER - 1)) begin
      pcnt  <= '0;
      mtime <= mtime + 64'd1;
    end else begin
      pcnt  <= pcnt + 32'd1;
    end
  end

  // Read FSM; every bus output is registered and prepared one edge ahead.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rid_q     <= '0;
      snap      <= '0;
      beat      <= '0;
      addr      <= '0;
      len       <= '0;
      size      <= '0;
      burst     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arvalid && arready_q) begin
            state     <= RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            addr      <= bus.araddr;
            len       <= bus.arlen;
            size      <= bus.arsize;
            burst     <= bus.arburst;
            rid_q     <= bus.arid;
            snap      <= mtime;
            beat      <= '0;
            rlast_q   <= (bus.arlen == 8'd0);
            if (beat_ok(bus.araddr, bus.arburst, bus.arsize)) begin
              rdata_q <= mtime;
              rresp_q <= RESP_OKAY;
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rready) begin
            if (beat == len) begin
              state     <= IDLE;
              arready_q <= 1'b1;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rresp_q   <= RESP_OKAY;
              rdata_q   <= '0;
            end else begin
              beat    <= beat_nxt;
              addr    <= addr_nxt;
              rlast_q <= (beat_nxt == len);
              if (beat_ok(addr_nxt, burst, size)) begin
                rdata_q <= snap;
                rresp_q <= RESP_OKAY;
              end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_clint.sv
// Directed bench for the CLINT: one DIVIDER=4 instance for most scenarios and
// one DIVIDER=1 instance for the 64-bit wrap.
module tb_ysyx_23060208_clint;

  localparam int          DIV  = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned vectors = 0;
  int unsigned errs = 0;
  int unsigned k = 0;

  always #5 clk = ~clk;

  // Non-reset edges since the last reset edge of the DIVIDER=4 instance.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  ysyx_23060208_clint_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b4 ();
  ysyx_23060208_clint_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();

  ysyx_23060208_clint #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CLINT_BASE(BASE), .DIVIDER(4))
    u4 (.clock(clk), .reset(rst), .bus(b4));
  ysyx_23060208_clint #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CLINT_BASE(BASE), .DIVIDER(1))
    u1 (.clock(clk), .reset(rst), .bus(b1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [63:0] d, input logic [1:0] r,
                      input logic l, input logic [3:0] id);
    chk({tag, ".rvalid"}, b4.rvalid, 1);
    chk({tag, ".rdata"},  b4.rdata,  d);
    chk({tag, ".rresp"},  b4.rresp,  r);
    chk({tag, ".rlast"},  b4.rlast,  l);
    chk({tag, ".rid"},    b4.rid,    id);
  endtask

  // Issue one AR on the DIVIDER=4 bus; returns #1 after the accepting edge
  // with the snapshot that edge should have captured.
  task automatic ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input bit hold,
                    output logic [63:0] snap);
    bit done;
    done = 1'b0;
    b4.araddr  = addr;
    b4.arid    = id;
    b4.arlen   = len;
    b4.arsize  = size;
    b4.arburst = burst;
    b4.arvalid = 1'b1;
    for (int i = 0; i < 16 && !done; i++) begin
      if (b4.arready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!hold) b4.arvalid = 1'b0;
    chk("ar_accept", done, 1);
    snap = 64'((k - 1) / DIV);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s;
    logic [63:0] s1;
    logic [63:0] ed;
    logic [1:0]  er;

    b4.arvalid = 0; b4.araddr = '0; b4.arid = '0; b4.arlen = '0;
    b4.arsize = '0; b4.arburst = '0; b4.rready = 1'b1;
    b1.arvalid = 0; b1.araddr = BASE; b1.arid = 4'h3; b1.arlen = '0;
    b1.arsize = 3'd3; b1.arburst = 2'b01; b1.rready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.arready", b4.arready, 0);
    chk("rst.rvalid",  b4.rvalid,  0);
    chk("rst.rlast",   b4.rlast,   0);
    chk("rst.rresp",   b4.rresp,   0);
    chk("rst.rdata",   b4.rdata,   0);
    chk("rst.rid",     b4.rid,     0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.arready", b4.arready, 1);

    // Single read after 40 idle cycles: snapshot 40/4 = 0xA
    repeat (39) @(posedge clk);
    #1;
    ar(BASE, 4'h3, 8'd0, 3'd3, 2'b01, 0, s);
    beat("single", s, 2'b00, 1, 4'h3);
    chk("single.hand", b4.rdata, 64'hA);
    @(posedge clk); #1;
    chk("single.done.rvalid",  b4.rvalid,  0);
    chk("single.done.arready", b4.arready, 1);

    // 64-bit wrap on the DIVIDER=1 instance
    force u1.mtime = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release u1.mtime;
    b1.arvalid = 1'b1;
    @(posedge clk); #1;
    b1.arvalid = 1'b0;
    chk("wrap1.rvalid", b1.rvalid, 1);
    chk("wrap1.rdata",  b1.rdata,  64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap1.rid",    b1.rid,    4'h3);
    @(posedge clk); #1;
    chk("wrap1.done.arready", b1.arready, 1);
    b1.arvalid = 1'b1;
    @(posedge clk); #1;
    b1.arvalid = 1'b0;
    chk("wrap2.rvalid", b1.rvalid, 1);
    chk("wrap2.rdata",  b1.rdata,  64'h0);
    @(posedge clk); #1;

    // INCR burst with rready toggling; beats at offsets 0x8/0xC error out
    b4.rready = 1'b0;
    ar(BASE, 4'h5, 8'd3, 3'd2, 2'b01, 0, s);
    for (int b = 0; b < 4; b++) begin
      ed = (b < 2) ? s : 64'h0;
      er = (b < 2) ? 2'b00 : 2'b10;
      beat("incr", ed, er, b == 3, 4'h5);
      @(posedge clk); #1;
      beat("incr_hold", ed, er, b == 3, 4'h5);
      b4.rready = 1'b1;
      @(posedge clk); #1;
      b4.rready = 1'b0;
    end
    chk("incr.done.rvalid",  b4.rvalid,  0);
    chk("incr.done.arready", b4.arready, 1);

    // WRAP burst: both beats SLVERR
    b4.rready = 1'b1;
    ar(BASE, 4'h9, 8'd1, 3'd3, 2'b10, 0, s);
    beat("wrap0", 64'h0, 2'b10, 0, 4'h9);
    @(posedge clk); #1;
    beat("wrap1", 64'h0, 2'b10, 1, 4'h9);
    @(posedge clk); #1;
    chk("wrap.done.rvalid", b4.rvalid, 0);

    // Upper word read at offset 4
    ar(BASE + 32'h4, 4'hA, 8'd0, 3'd2, 2'b01, 0, s);
    beat("hi", s, 2'b00, 1, 4'hA);
    chk("hi.word", 64'(b4.rdata[63:32]), 64'(s[63:32]));
    @(posedge clk); #1;

    // Back-to-back reads with arvalid held
    ar(BASE, 4'h6, 8'd0, 3'd3, 2'b01, 1, s1);
    beat("b2b0", s1, 2'b00, 1, 4'h6);
    @(posedge clk); #1;
    chk("b2b.gap.rvalid",  b4.rvalid,  0);
    chk("b2b.gap.arready", b4.arready, 1);
    @(posedge clk); #1;
    b4.arvalid = 1'b0;
    s = 64'((k - 1) / DIV);
    beat("b2b1", s, 2'b00, 1, 4'h6);
    chk("b2b.mono", b4.rdata >= s1, 1);
    @(posedge clk); #1;
    chk("b2b.done.rvalid", b4.rvalid, 0);

    // Reset during beat 1 of a 4-beat burst
    ar(BASE, 4'h1, 8'd3, 3'd3, 2'b01, 0, s);
    beat("rb0", s, 2'b00, 0, 4'h1);
    @(posedge clk); #1;
    beat("rb1", 64'h0, 2'b10, 0, 4'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rb.rst.rvalid",  b4.rvalid,  0);
    chk("rb.rst.arready", b4.arready, 0);
    chk("rb.rst.rlast",   b4.rlast,   0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rb.post.arready", b4.arready, 1);
    chk("rb.post.rvalid",  b4.rvalid,  0);
    ar(BASE, 4'h2, 8'd0, 3'd3, 2'b01, 0, s);
    beat("rb.restart", s, 2'b00, 1, 4'h2);
    chk("rb.restart.hand", b4.rdata, 64'h0);
    @(posedge clk); #1;
    chk("rb.restart.done", b4.rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_clint.md
# ysyx_23060208_clint

AXI4 read-only responder for the core-local timer (CLINT) that sits behind the interconnect's CLINT port and answers EXU loads in 0x0200_0000–0x0200_FFFF. Holds a free-running 64-bit `mtime` counter advanced by a programmable prescaler. Returns an atomic 64-bit snapshot on the 64-bit R channel and supports single-beat and INCR/FIXED burst reads with ID echo and error responses.

## Interface
- `DATA_WIDTH`, 32: base word width; R data bus is `DATA_WIDTH*2` = 64 bits.
- `ADDR_WIDTH`, 32: address width.
- `CLINT_BASE`, 32'h0200_0000: base address; offset = `araddr - CLINT_BASE`, 16 bits used.
- `DIVIDER`, 1: clock cycles per `mtime` increment, ≥1.

- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `arready`  out  1  AR accept.
- `arvalid`  in  1  AR request valid.
- `araddr`  in  ADDR_WIDTH  byte address of first beat.
- `arid`  in  4  transaction ID.
- `arlen`  in  8  beats minus one.
- `arsize`  in  3  bytes per beat = 1<<arsize; legal 0–3.
- `arburst`  in  2  00 FIXED, 01 INCR, 10 WRAP.
- `rready`  in  1  R accept.
- `rvalid`  out  1  R beat valid.
- `rresp`  out  2  00 OKAY, 10 SLVERR.
- `rdata`  out  64  read data.
- `rlast`  out  1  last beat of burst.
- `rid`  out  4  echo of captured `arid`.

## Operation
- Prescaler: `pcnt` counts 0..DIVIDER-1 each cycle; when `pcnt == DIVIDER-1`, `pcnt` ← 0 and `mtime` ← `mtime + 1` (mod 2^64, 0xFFFF_FFFF_FFFF_FFFF wraps to 0). DIVIDER=1: `mtime` increments every cycle. Counter runs regardless of bus activity.
- FSM states IDLE, RESP.
  - IDLE: `arready`=1, `rvalid`=0. On `arvalid && arready`: capture `araddr`, `arid`, `arlen`, `arsize`, `arburst`; `snap` ← current `mtime` (pre-increment value of that cycle); beat counter ← 0; go RESP.
  - RESP: `arready`=0, `rvalid`=1. Outputs held stable while `rready`=0. On `rvalid && rready`: if beat counter == captured `arlen` go IDLE, else beat counter+1 and advance address.
- Address advance: INCR adds `1<<arsize`; FIXED keeps address; WRAP is unsupported.
- Per-beat decode on current beat address offset:
  - offset 0x0–0x7 and burst ≠ WRAP and arsize ≤ 3: `rdata` = `snap` (low word lanes [31:0] = mtime[31:0], lanes [63:32] = mtime[63:32]; byte lanes selected by master via address), `rresp`=00.
  - otherwise (offset ≥ 0x8, address outside base..base+0xFFFF, WRAP, arsize > 3): `rdata`=0, `rresp`=10. Burst still completes all `arlen+1` beats.
- All beats of one burst return the same `snap`; a new AR captures a new snapshot.
- `rlast` = 1 iff RESP and beat counter == captured `arlen`.
- `rid` = captured `arid` on every beat.
- No write channel; writes are never routed here.

## Timing
- Reset (synchronous, when `reset`=1 at a clock edge): state IDLE, `mtime`=0, `pcnt`=0, beat counter=0, `snap`=0. During reset cycles `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=00, `rdata`=0, `rid`=0. `arready` rises the first cycle after `reset` deasserts.
- Reset mid-burst: transaction abandoned, next cycle is IDLE; no further beats.
- AR handshake at cycle N → first `rvalid` at N+1 (registered), single-cycle latency.
- Beat k handshake at cycle M → beat k+1 valid at M+1; zero-bubble bursts when `rready` held high.
- Last-beat handshake at M → IDLE at M+1 with `arready`=1; next AR accepted at earliest M+1, its first beat at M+2.
- `arvalid` asserted while in RESP is not accepted; master must hold it (AXI rule).
- Snapshot coincident with increment: `snap` takes the value visible before that edge's increment.

## Test plan
- DIVIDER=4, reset released at cycle 0, idle 40 cycles, single read araddr=0x0200_0000, arlen=0, arsize=3 → one beat, rdata=0x0000_0000_0000_000A (±1 by handshake cycle, checked against model), rresp=00, rlast=1, rid=arid.
- DIVIDER=1, force mtime to 0xFFFF_FFFF_FFFF_FFFE via long run or backdoor, read twice → second read returns small post-wrap value; mtime wraps to 0.
- INCR burst araddr=0x0200_0000, arlen=3, arsize=2, arid=0x5, rready toggled 1/0 → 4 beats, beats 0–1 OKAY with identical snap, beats 2–3 (offset 0x8, 0xC) rdata=0 rresp=10, rlast only on beat 3, rid=5, data stable while rready=0.
- WRAP burst arlen=1 → 2 beats both rresp=10, rdata=0; then INCR read at 0x0200_0004 size 2 → rresp=00, rdata[63:32]=snap high.
- Reset asserted during beat 1 of arlen=3 burst → rvalid=0 next cycle, arready=1 the cycle after reset drops, mtime restarts at 0.
- Back-to-back reads with arvalid held high → second AR accepted cycle after first rlast handshake, second rvalid one cycle later, second snap ≥ first.
